// File: rtl/frame_buf_pkg.sv
// frame_buf_pkg: shared state encodings and polarity constants for the ping-pong frame buffer controller
package frame_buf_pkg;
  localparam logic ASSERT_H = 1'b1;
  localparam logic DEASSERT_H = 1'b0;
  typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} w_state_t;
  typedef enum logic {R_IDLE, R_READ} r_state_t;
endpackage

// File: rtl/frame_buf_ctrl_if.sv
// frame_buf_ctrl_if: writer/reader handshake and external memory strobes of the frame buffer controller
interface frame_buf_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
);
  logic wr_valid;
  logic wr_sof;
  logic wr_ready;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] mem_wr_data;
  logic rd_req;
  logic frame_rdy;
  logic mem_wr_en;
  logic [ADDR_WIDTH:0] mem_wr_addr;
  logic mem_rd_en;
  logic [ADDR_WIDTH:0] mem_rd_addr;
  logic rd_valid;
  logic rd_last;
  logic overrun;
  modport master (
    output wr_valid, wr_sof, wr_data, rd_req,
    input  wr_ready, frame_rdy, mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_en, mem_rd_addr, rd_valid, rd_last, overrun
  );
  modport slave (
    input  wr_valid, wr_sof, wr_data, rd_req,
    output wr_ready, frame_rdy, mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_en, mem_rd_addr, rd_valid, rd_last, overrun
  );
endinterface

// File: rtl/frame_buf_ctrl.sv
// frame_buf_ctrl: ping-pong frame buffer controller driving an external two-bank memory
// (address MSB selects the bank, low bits are the word pointer).
module frame_buf_ctrl
  import frame_buf_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
) (
  input  logic wr_clk,
  input  logic reset,
  frame_buf_ctrl_if.slave bus
);
  w_state_t w_state;
  r_state_t r_state;
  logic wr_buf, rd_buf;
  logic [1:0] full;
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr, wr_cur;
  logic wr_acc, wr_start, wr_drop, wr_en, wr_done, rd_en, rd_done, rd_valid_q, overrun_q;
  // a start-of-frame inside W_FILL restarts the same bank, so it never needs a free check
  always_comb begin
    wr_acc = bus.wr_valid & !reset;
    wr_start = wr_acc & bus.wr_sof & (w_state == W_FILL | !full[wr_buf]);
    wr_drop = wr_acc & bus.wr_sof & w_state != W_FILL & full[wr_buf];
    wr_en = wr_start | (wr_acc & w_state == W_FILL);
    wr_cur = wr_start ? '0 : wr_ptr;
    wr_done = wr_en & (&wr_cur);
    rd_en = bus.rd_req & full[rd_buf] & !reset;
    rd_done = rd_en & (&rd_ptr);
  end
  assign bus.wr_ready = reset ? DEASSERT_H : ASSERT_H;
  assign bus.frame_rdy = full[rd_buf] & !reset;
  assign bus.mem_wr_en = wr_en;
  assign bus.mem_wr_addr = reset ? '0 : {wr_buf, wr_cur};
  assign bus.mem_wr_data = DATA_WIDTH'(bus.wr_data);
  assign bus.mem_rd_en = rd_en;
  assign bus.mem_rd_addr = reset ? '0 : {rd_buf, rd_ptr};
  assign bus.rd_last = rd_done;
  assign bus.rd_valid = rd_valid_q;
  assign bus.overrun = overrun_q;
  // writer sets and reader clears always hit different banks, so both apply together
  always_ff @(posedge wr_clk) begin
    if (reset) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
      wr_buf <= DEASSERT_H;
      rd_buf <= DEASSERT_H;
      full <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      rd_valid_q <= DEASSERT_H;
      overrun_q <= DEASSERT_H;
    end else begin
      w_state <= wr_done ? W_IDLE : wr_en ? W_FILL : wr_drop ? W_DROP : w_state;
      r_state <= rd_done ? R_IDLE : rd_en ? R_READ : r_state;
      wr_buf <= wr_buf ^ wr_done;
      rd_buf <= rd_buf ^ rd_done;
      wr_ptr <= wr_done ? '0 : wr_en ? wr_cur + 1'b1 : wr_ptr;
      rd_ptr <= rd_done ? '0 : rd_en ? rd_ptr + 1'b1 : rd_ptr;
      full <= (full | (2'(wr_done) << wr_buf)) & ~(2'(rd_done) << rd_buf);
      rd_valid_q <= rd_en;
      overrun_q <= wr_drop;
    end
  end
endmodule
